rr_arb_4_1: RTL
===============

RR_ARB_4_1 -- requirements
Module: rr_arb_4_1

Interface
REQ-001 Parameter W, default 4: data width of every channel and of the output.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-channel valid; req[i] qualifies d<i>.
REQ-005 d0, d1, d2, d3  input  W each  channel data.
REQ-006 gnt  output  4  one-hot accept strobe; gnt[i]=1 means d<i> is captured at this edge.
REQ-007 sel  output  2  index of the channel held in the output register; drives a downstream 4:1 mux select.
REQ-008 y  output  W  registered selected data.
REQ-009 y_vld  output  1  y holds an undelivered word.
REQ-010 y_rdy  input  1  consumer accepts y when y_vld=1 and y_rdy=1.

Function
REQ-011 load_ok = !y_vld | y_rdy; gnt is 0 whenever load_ok=0 or req=0.
REQ-012 When load_ok=1 and req!=0, exactly one gnt bit is set, chosen by round-robin search starting at index (ptr+1) mod 4 and wrapping 3->0.
REQ-013 gnt is combinational from req, ptr, y_vld, y_rdy; it is never registered.
REQ-014 On a granted edge: y<=d<i>, sel<=i, ptr<=i, y_vld<=1.
REQ-015 On an edge with y_vld=1, y_rdy=1 and no grant: y_vld<=0; y and sel keep their values.
REQ-016 Backpressure: when y_vld=1 and y_rdy=0, y, sel, y_vld and ptr are held unchanged.
REQ-017 Simultaneous drain and grant in one cycle: the new word replaces the old one, y_vld stays 1, throughput is 1 word/cycle.
REQ-018 Latency: a word granted at edge N is visible on y with y_vld=1 after edge N.
REQ-019 With no requests, ptr does not change.
REQ-020 A single persistent requester is granted every cycle that load_ok=1.
REQ-021 Fairness: with all 4 req high and y_rdy=1, the grant sequence is 0,1,2,3,0,... with no channel skipped.

Reset
REQ-022 When rst=1 at an edge: y_vld<=0, y<=0, sel<=0, ptr<=3, so channel 0 has first priority.
REQ-023 While rst=1, gnt is forced to 0.
REQ-024 Reset asserted mid-transfer discards the held word; no gnt is issued during that cycle.

Configuration
REQ-025 With macro RR_ARB_XFER_CNT_EN defined, the block adds output xfer_cnt (8 bits), which counts completed output handshakes (y_vld & y_rdy). The count resets to 0 and wraps from 255 to 0.
REQ-026 Without RR_ARB_XFER_CNT_EN, the port and its counter do not exist, and all other behaviour is identical.

Structure
REQ-027 Package rr_arb_pkg shall hold: CH_NUM=4, SEL_W=2, the default W=4, and PTR_RST=2'd3.
REQ-028 Sub-module rr_pick4 is a combinational rotate-priority encoder with inputs req[3:0] and ptr[1:0] and outputs onehot[3:0], idx[1:0] and any.
REQ-029 The output register, ptr and the counter reside in rr_arb_4_1 only.

Verification
REQ-030 Reset then req=4'b1111, y_rdy=1 -> gnt sequence 0001,0010,0100,1000,0001; sel follows one cycle later as 0,1,2,3,0.
REQ-031 d2=4'hA, req=4'b0100, y_rdy=0 -> one gnt=0100; then y=A, sel=2, y_vld=1 held for 5 cycles with gnt=0; raise y_rdy -> next gnt=0100 on the same cycle.
REQ-032 ptr=2 (after a grant to channel 2), req=4'b0011 -> gnt=0001 (wrap 3->0 search skips empty 3).
REQ-033 Streaming with y_rdy=1, req=4'b1001 -> alternating gnt 0001/1000, y_vld stays 1 every cycle after the first.
REQ-034 rst pulsed while y_vld=1, y_rdy=0 -> next cycle y_vld=0, y=0, sel=0; the first grant after reset goes to the lowest requesting index.
REQ-035 With RR_ARB_XFER_CNT_EN: 257 handshakes -> xfer_cnt=1; without the macro, the build has no xfer_cnt port.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared constants for the 4:1 round-robin arbiter slice.
//   CH_NUM  - number of arbitrated channels
//   SEL_W   - width of a channel index
//   W_DEF   - default data width of each channel and of the output
//   PTR_RST - pointer value after reset (last-granted = 3, so channel 0 wins first)
package rr_arb_pkg;

    localparam int              CH_NUM  = 4;
    localparam int              SEL_W   = 2;
    localparam int              W_DEF   = 4;
    localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

endpackage : rr_arb_pkg

// File: rtl/rr_arb_4_1_pick.sv
// rr_pick4: combinational rotate-priority encoder.
//   req    [3:0] in  - request vector
//   ptr    [1:0] in  - index granted last; search starts at ptr+1 and wraps 3->0
//   onehot [3:0] out - one-hot winner (all zero when req == 0)
//   idx    [1:0] out - binary index of the winner (0 when req == 0)
//   any          out - at least one request present
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [CH_NUM-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [CH_NUM-1:0] onehot,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    // Walk the channels in rotated order and latch the first requester found.
    always_comb begin
        logic [SEL_W-1:0] w_cand;
        onehot = {CH_NUM{1'b0}};
        idx    = {SEL_W{1'b0}};
        any    = 1'b0;
        w_cand = {SEL_W{1'b0}};
        for (int k = 1; k <= CH_NUM; k++) begin
            // Index arithmetic wraps naturally in SEL_W bits.
            w_cand = ptr + SEL_W'(k);
            if (!any && req[w_cand]) begin
                any            = 1'b1;
                idx            = w_cand;
                onehot[w_cand] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule : rr_pick4

// File: rtl/rr_arb_4_1.sv
// rr_arb_4_1: 4:1 round-robin arbiter with a single registered output stage.
//   clk, rst        - clock, synchronous active-high reset
//   req [3:0]       - per-channel valid, d0..d3 - channel data (W bits)
//   gnt [3:0]       - combinational one-hot accept strobe (channel captured this edge)
//   sel [1:0]       - index of the channel held in y
//   y, y_vld, y_rdy - output word, valid, and consumer ready
//   xfer_cnt [7:0]  - completed output handshakes, wraps at 256
//                     (present only when RR_ARB_XFER_CNT_EN is defined)
module rr_arb_4_1
    import rr_arb_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] req,
    input  logic [W-1:0]      d0,
    input  logic [W-1:0]      d1,
    input  logic [W-1:0]      d2,
    input  logic [W-1:0]      d3,
    input  logic              y_rdy,
    output logic [CH_NUM-1:0] gnt,
    output logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      y,
    output logic              y_vld
`ifdef RR_ARB_XFER_CNT_EN
    ,
    output logic [7:0]        xfer_cnt
`endif
);

    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  r_sel;
    logic [W-1:0]      r_y;
    logic              r_y_vld;

    logic [CH_NUM-1:0] w_onehot;
    logic [SEL_W-1:0]  w_idx;
    logic              w_any;
    logic              w_load_ok;
    logic              w_grant;
    logic [W-1:0]      w_data;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_onehot),
        .idx    (w_idx),
        .any    (w_any)
    );

    // The output slot can take a new word when empty or being drained this cycle.
    assign w_load_ok = !r_y_vld || y_rdy;
    // Reset suppresses the grant so nothing is accepted while the stage is cleared.
    assign w_grant   = w_load_ok && w_any && !rst;
    assign gnt       = w_grant ? w_onehot : {CH_NUM{1'b0}};

    // Select the winning channel's data for capture.
    always_comb begin
        w_data = d0;
        case (w_idx)
            2'd0:    w_data = d0;
            2'd1:    w_data = d1;
            2'd2:    w_data = d2;
            2'd3:    w_data = d3;
            default: w_data = d0;
        endcase
    end

    // Output stage and round-robin pointer; a grant also covers the drain-and-refill case.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_vld <= 1'b0;
            r_y     <= {W{1'b0}};
            r_sel   <= {SEL_W{1'b0}};
            r_ptr   <= PTR_RST;
        end else if (w_grant) begin
            r_y_vld <= 1'b1;
            r_y     <= w_data;
            r_sel   <= w_idx;
            r_ptr   <= w_idx;
        end else if (r_y_vld && y_rdy) begin
            r_y_vld <= 1'b0;
        end else begin
            r_y_vld <= r_y_vld;
        end
    end

    assign y     = r_y;
    assign sel   = r_sel;
    assign y_vld = r_y_vld;

`ifdef RR_ARB_XFER_CNT_EN
    logic [7:0] r_xfer_cnt;

    // Count completed output handshakes, wrapping at 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= 8'd0;
        end else if (r_y_vld && y_rdy) begin
            r_xfer_cnt <= r_xfer_cnt + 8'd1;
        end else begin
            r_xfer_cnt <= r_xfer_cnt;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule : rr_arb_4_1
